// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car drive and the elevator controller:
// direction and floor encodings, car state enum, and small floor helpers.
package elevator_pkg;

    typedef enum logic [1:0] {
        DIR_STOP    = 2'b00,
        DIR_UP      = 2'b01,
        DIR_DOWN    = 2'b10,
        DIR_ILLEGAL = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        FLOOR_1 = 2'b00,
        FLOOR_2 = 2'b01,
        FLOOR_3 = 2'b10
    } floor_e;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_MOVING       = 3'd1,
        ST_DOOR_OPENING = 3'd2,
        ST_DOOR_OPEN    = 3'd3,
        ST_DOOR_CLOSING = 3'd4,
        ST_FAULT        = 3'd5
    } car_state_e;

    localparam int unsigned TIMER_W = 4;

    // True when a one-floor move in direction dir from floor stays inside the shaft.
    function automatic logic can_move(input logic [1:0] dir, input logic [1:0] floor);
        return ((dir == DIR_UP) && (floor != FLOOR_3)) ||
               ((dir == DIR_DOWN) && (floor != FLOOR_1));
    endfunction

    // Floor reached after one move in direction dir.
    function automatic logic [1:0] step_floor(input logic [1:0] dir, input logic [1:0] floor);
        if (dir == DIR_UP)   return floor + 2'd1;
        if (dir == DIR_DOWN) return floor - 2'd1;
        return floor;
    endfunction

endpackage

// File: rtl/elevator_car_drive_if.sv
// Command/status bundle between the elevator controller (master) and the
// car drive (slave).
interface elevator_car_drive_if;

    logic [1:0] dir_cmd;
    logic       door_cmd;
    logic       elevator_arrived;
    logic [1:0] car_floor;
    logic       door_open_sts;
    logic       moving;
    logic       fault;

    modport master (
        output dir_cmd, door_cmd,
        input  elevator_arrived, car_floor, door_open_sts, moving, fault
    );

    modport slave (
        input  dir_cmd, door_cmd,
        output elevator_arrived, car_floor, door_open_sts, moving, fault
    );

endinterface

// File: rtl/elev_timer.sv
// Loadable down-counter shared by travel and door timing. Saturates at zero;
// zero_o flags an expired count, last_o flags the final count before zero.
module elev_timer
    import elevator_pkg::*;
#(
    parameter int unsigned W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;

    // Count register: load has priority over decrement; holds at zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/elevator_car_drive.sv
// Elevator car drive: three-floor car with committed one-floor moves, a
// door sequencer and a sticky fault interlock that only reset clears.
module elevator_car_drive
    import elevator_pkg::*;
#(
    parameter int unsigned T_TRAVEL = 8,
    parameter int unsigned T_DOOR   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    elevator_car_drive_if.slave  bus
);

    // Travel loads one less than T_TRAVEL: the load happens on the IDLE
    // sampling edge itself, so the arrival edge lands T_TRAVEL cycles later.
    localparam logic [TIMER_W-1:0] TRAVEL_RELOAD = TIMER_W'(T_TRAVEL - 1);
    localparam logic [TIMER_W-1:0] DOOR_RELOAD   = TIMER_W'(T_DOOR);

    car_state_e   state_q, state_d;
    logic [1:0]   floor_q, floor_d;
    logic [1:0]   dir_q, dir_d;
    logic         arrived_q, arrived_d;
    logic         door_open_q;
    logic         moving_q;
    logic         fault_q;

    logic               tmr_load;
    logic               tmr_dec;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_zero;
    logic               tmr_last;

    elev_timer #(.W(TIMER_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .dec_i      (tmr_dec),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero),
        .last_o     (tmr_last)
    );

    // Transition decode: next state, floor, latched direction and timer control.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        arrived_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_val   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if ((bus.dir_cmd == DIR_ILLEGAL) ||
                    ((bus.dir_cmd != DIR_STOP) && bus.door_cmd)) begin
                    state_d = ST_FAULT;
                end else if (bus.dir_cmd == DIR_STOP) begin
                    if (bus.door_cmd) begin
                        state_d  = ST_DOOR_OPENING;
                        tmr_load = 1'b1;
                        tmr_val  = DOOR_RELOAD;
                    end
                end else if (can_move(bus.dir_cmd, floor_q)) begin
                    state_d  = ST_MOVING;
                    dir_d    = bus.dir_cmd;
                    tmr_load = 1'b1;
                    tmr_val  = TRAVEL_RELOAD;
                end else begin
                    state_d = ST_FAULT;
                end
            end

            ST_MOVING: begin
                if (bus.door_cmd || (bus.dir_cmd == DIR_ILLEGAL)) begin
                    state_d = ST_FAULT;
                end else if (tmr_zero) begin
                    floor_d   = step_floor(dir_q, floor_q);
                    arrived_d = 1'b1;
                    // Only the arrival edge looks at dir_cmd: continue if the
                    // same direction is still requested and another floor exists.
                    if ((bus.dir_cmd == dir_q) && can_move(dir_q, floor_d)) begin
                        tmr_load = 1'b1;
                        tmr_val  = TRAVEL_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_DOOR_OPENING: begin
                tmr_dec = 1'b1;
                if (bus.dir_cmd != DIR_STOP) begin
                    state_d = ST_FAULT;
                end else if (tmr_last) begin
                    state_d = ST_DOOR_OPEN;
                end
            end

            ST_DOOR_OPEN: begin
                if (bus.dir_cmd != DIR_STOP) begin
                    state_d = ST_FAULT;
                end else if (!bus.door_cmd) begin
                    state_d  = ST_DOOR_CLOSING;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_RELOAD;
                end
            end

            ST_DOOR_CLOSING: begin
                tmr_dec = 1'b1;
                if (bus.dir_cmd != DIR_STOP) begin
                    state_d = ST_FAULT;
                end else if (tmr_last) begin
                    state_d = ST_IDLE;
                end
            end

            ST_FAULT: begin
                state_d = ST_FAULT;
            end

            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // State and registered outputs; door status freezes while in FAULT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            floor_q     <= FLOOR_1;
            dir_q       <= DIR_STOP;
            arrived_q   <= 1'b0;
            door_open_q <= 1'b0;
            moving_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            arrived_q <= arrived_d;
            moving_q  <= (state_d == ST_MOVING);
            fault_q   <= (state_d == ST_FAULT);
            if (state_d != ST_FAULT) begin
                door_open_q <= (state_d == ST_DOOR_OPEN);
            end
        end
    end

    assign bus.elevator_arrived = arrived_q;
    assign bus.car_floor        = floor_q;
    assign bus.door_open_sts    = door_open_q;
    assign bus.moving           = moving_q;
    assign bus.fault            = fault_q;

endmodule

// File: tb/tb_elevator_car_drive.sv
// Scoreboard bench for elevator_car_drive: directed scenarios followed by
// random commands, all predicted by a floor/countdown reference model.
module tb_elevator_car_drive;

    localparam int T_TRAVEL = 8;
    localparam int T_DOOR   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    elevator_car_drive_if bus ();

    elevator_car_drive #(
        .T_TRAVEL (T_TRAVEL),
        .T_DOOR   (T_DOOR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       arrived;
        logic [1:0] floor;
        logic       door_open;
        logic       moving;
        logic       fault;
    } obs_t;

    obs_t exp_q[$];   // expected outputs after each driven edge
    int   arr_q[$];   // expected floor number (1..3) of each arrival pulse

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Floors are numbered 1..3, direction is a signed step, and every phase is
    // a countdown of remaining cycles until its event.
    localparam int M_IDLE = 0, M_TRAVEL = 1, M_OPENING = 2, M_OPEN = 3, M_CLOSING = 4, M_FAULT = 5;

    int m_mode  = M_IDLE;
    int m_floor = 1;
    int m_step  = 0;
    int m_left  = 0;
    bit m_door_open = 1'b0;

    task automatic model_step(input logic [1:0] dir, input logic door, input logic r);
        bit arrived;
        int step;
        arrived = 1'b0;
        step = (dir == 2'd1) ? 1 : (dir == 2'd2) ? -1 : 0;
        if (r) begin
            m_mode = M_IDLE; m_floor = 1; m_left = 0; m_door_open = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (dir == 2'd3 || (dir != 2'd0 && door) ||
                        (step != 0 && (m_floor + step < 1 || m_floor + step > 3)))
                        m_mode = M_FAULT;
                    else if (step != 0) begin
                        m_mode = M_TRAVEL; m_step = step; m_left = T_TRAVEL;
                    end else if (door) begin
                        m_mode = M_OPENING; m_left = T_DOOR;
                    end
                end
                M_TRAVEL: begin
                    if (door || dir == 2'd3) m_mode = M_FAULT;
                    else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_floor += m_step;
                            arrived = 1'b1;
                            arr_q.push_back(m_floor);
                            if (step == m_step && m_floor + m_step >= 1 && m_floor + m_step <= 3)
                                m_left = T_TRAVEL;
                            else
                                m_mode = M_IDLE;
                        end
                    end
                end
                M_OPENING: begin
                    if (dir != 2'd0) m_mode = M_FAULT;
                    else begin
                        m_left--;
                        if (m_left == 0) m_mode = M_OPEN;
                    end
                end
                M_OPEN: begin
                    if (dir != 2'd0) m_mode = M_FAULT;
                    else if (!door) begin
                        m_mode = M_CLOSING; m_left = T_DOOR;
                    end
                end
                M_CLOSING: begin
                    if (dir != 2'd0) m_mode = M_FAULT;
                    else begin
                        m_left--;
                        if (m_left == 0) m_mode = M_IDLE;
                    end
                end
                default: ;
            endcase
        end
        if (m_mode != M_FAULT) m_door_open = (m_mode == M_OPEN);
        exp_q.push_back('{arrived:   arrived,
                          floor:     2'(m_floor - 1),
                          door_open: m_door_open,
                          moving:    (m_mode == M_TRAVEL),
                          fault:     (m_mode == M_FAULT)});
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [1:0] dir, input logic door, input logic r);
        @(negedge clk);
        bus.dir_cmd  = dir;
        bus.door_cmd = door;
        rst          = r;
        model_step(dir, door, r);
    endtask

    task automatic drive_n(input logic [1:0] dir, input logic door, input int n);
        for (int k = 0; k < n; k++) drive(dir, door, 1'b0);
    endtask

    // ---------------- monitor ----------------
    obs_t mon_act, mon_exp;
    int   mon_floor;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = '{arrived:   bus.elevator_arrived,
                        floor:     bus.car_floor,
                        door_open: bus.door_open_sts,
                        moving:    bus.moving,
                        fault:     bus.fault};
            check("outputs{arr,floor,door,mov,fault}", 32'(mon_act), 32'(mon_exp));
        end
        if (bus.elevator_arrived === 1'b1) begin
            check("arrival_expected", 32'(arr_q.size() > 0), 32'd1);
            if (arr_q.size() > 0) begin
                mon_floor = arr_q.pop_front();
                check("arrival_floor", 32'(bus.car_floor), 32'(mon_floor - 1));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic [1:0] r_dir;
    logic       r_door;
    int         fault_age;
    int         pick;

    initial begin
        bus.dir_cmd  = 2'b00;
        bus.door_cmd = 1'b0;

        // Reset, then up from floor 1 held: arrivals at cycles 8 and 16, then idle.
        drive(2'b00, 1'b0, 1'b1);
        drive(2'b00, 1'b0, 1'b1);
        drive_n(2'b01, 1'b0, 17);
        drive_n(2'b00, 1'b0, 3);

        // At floor 3, down for a single cycle: one arrival at floor 2.
        drive(2'b10, 1'b0, 1'b0);
        drive_n(2'b00, 1'b0, 10);

        // Door open, dwell, close.
        drive_n(2'b00, 1'b1, 4);
        drive_n(2'b00, 1'b0, 4);

        // Direction command while the door is open: sticky fault, then reset.
        drive_n(2'b00, 1'b1, 3);
        drive(2'b01, 1'b1, 1'b0);
        drive_n(2'b00, 1'b0, 5);
        drive(2'b00, 1'b0, 1'b1);
        drive_n(2'b00, 1'b0, 2);

        // Up to floor 2 then floor 3, then up at the top floor: fault, no arrival.
        drive(2'b01, 1'b0, 1'b0);
        drive_n(2'b00, 1'b0, 9);
        drive(2'b01, 1'b0, 1'b0);
        drive_n(2'b00, 1'b0, 9);
        drive(2'b01, 1'b0, 1'b0);
        drive_n(2'b00, 1'b0, 10);
        drive(2'b00, 1'b0, 1'b1);

        // Illegal direction code in IDLE: fault, no arrival.
        drive(2'b11, 1'b0, 1'b0);
        drive_n(2'b00, 1'b0, 10);
        drive(2'b00, 1'b0, 1'b1);

        // Reset during travel: back to floor 1, idle, no arrival pulse.
        drive(2'b00, 1'b0, 1'b0);
        drive_n(2'b01, 1'b0, 4);
        drive(2'b01, 1'b0, 1'b1);
        drive_n(2'b00, 1'b0, 12);

        // Random commands; faults are cleared by reset a few cycles later.
        r_dir = 2'b00; r_door = 1'b0; fault_age = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_mode == M_FAULT) begin
                fault_age++;
                if (fault_age > 3) begin
                    drive(2'b00, 1'b0, 1'b1);
                    fault_age = 0; r_dir = 2'b00; r_door = 1'b0;
                    continue;
                end
            end
            if ($urandom_range(99) < 15) begin
                pick  = int'($urandom_range(99));
                r_dir = (pick < 50) ? 2'b00 : (pick < 73) ? 2'b01 : (pick < 97) ? 2'b10 : 2'b11;
            end
            if ($urandom_range(99) < 6) r_door = ~r_door;
            drive(r_dir, r_door, ($urandom_range(999) < 3) ? 1'b1 : 1'b0);
        end

        drive_n(2'b00, 1'b0, 2);
        @(posedge clk);
        #2;
        check("arrival_queue_drained", 32'(arr_q.size()), 32'd0);
        check("expect_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_car_drive.md
ELEVATOR_CAR_DRIVE -- requirements
Module: elevator_car_drive

Interface
REQ-001 The block SHALL have parameter T_TRAVEL, default 8, cycles of car travel between adjacent floors, legal range 1..15.
REQ-002 The block SHALL have parameter T_DOOR, default 2, cycles of door travel (opening or closing), legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1, clock; reset rst, synchronous, active-high; clock clk.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port dir_cmd, input, 2, motion command: 00 stop, 01 up, 10 down, 11 illegal.
REQ-006 The block SHALL have port door_cmd, input, 1, door open request (1 = open, 0 = close).
REQ-007 The block SHALL have port elevator_arrived, output, 1, single-cycle pulse on reaching a floor.
REQ-008 The block SHALL have port car_floor, output, 2, current floor: 00 = floor 1, 01 = floor 2, 10 = floor 3.
REQ-009 The block SHALL have port door_open_sts, output, 1, high only when the door is fully open.
REQ-010 The block SHALL have port moving, output, 1, high while the car is travelling.
REQ-011 The block SHALL have port fault, output, 1, sticky fault flag.

Function
REQ-012 The FSM SHALL have states IDLE, MOVING, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING and FAULT.
REQ-013 In IDLE with dir_cmd=00 and door_cmd=1, the FSM SHALL enter DOOR_OPENING and load the timer with T_DOOR.
REQ-014 In IDLE with dir_cmd=01 and car_floor<2, or dir_cmd=10 and car_floor>0, door_cmd=0, the FSM SHALL enter MOVING, latch the direction and load the timer with T_TRAVEL-1.
REQ-015 In MOVING, the timer SHALL decrement each cycle; in the cycle it reads 0, car_floor SHALL step ±1 and elevator_arrived SHALL be 1 in that same cycle only.
REQ-016 Arrival latency SHALL be exactly T_TRAVEL cycles from the IDLE cycle that samples a valid dir_cmd.
REQ-017 On the arrival cycle, if dir_cmd still equals the latched direction and the next floor is in range, the FSM SHALL stay in MOVING with the timer reloaded; otherwise it SHALL enter IDLE.
REQ-018 Changes to dir_cmd during travel (other than at arrival) SHALL be ignored; motion is committed.
REQ-019 DOOR_OPENING SHALL last T_DOOR cycles then enter DOOR_OPEN; a door_cmd drop during DOOR_OPENING SHALL NOT abort opening.
REQ-020 In DOOR_OPEN, door_cmd=0 SHALL enter DOOR_CLOSING (timer=T_DOOR), which SHALL return to IDLE after T_DOOR cycles.
REQ-021 The FSM SHALL enter FAULT on any of: dir_cmd=11; dir_cmd up at floor 3 or down at floor 1 while in IDLE; dir_cmd≠00 in any door state; door_cmd=1 in MOVING.
REQ-022 In IDLE with dir_cmd≠00 and door_cmd=1 in the same cycle, the FSM SHALL enter FAULT (interlock).
REQ-023 FAULT SHALL be left only by rst; in FAULT, moving=0, elevator_arrived=0, car_floor and door_open_sts SHALL be held.
REQ-024 The moving output SHALL equal (state==MOVING), and door_open_sts SHALL equal (state==DOOR_OPEN); all outputs SHALL be registered.

Reset
REQ-025 rst SHALL force IDLE, car_floor=00, timer=0, elevator_arrived=0, door_open_sts=0, moving=0 and fault=0, including mid-travel or mid-door motion.

Structure
REQ-026 Shared package elevator_pkg SHALL hold the direction encodings (DIR_STOP, DIR_UP, DIR_DOWN), the floor encodings and the car state enum, shared with the elevator controller.
REQ-027 A single sub-module elev_timer (4-bit loadable down-counter with zero flag) SHALL serve both travel and door timing.

Verification (T_TRAVEL=8, T_DOOR=2)
REQ-028 Bench SHALL cover: reset, then dir_cmd=01 held from cycle 0 -> elevator_arrived at cycle 8 (car_floor=01) and at cycle 16 (car_floor=10), then IDLE.
REQ-029 Bench SHALL cover: at floor 3, dir_cmd=10 for one cycle -> single arrival after 8 cycles with car_floor=01, moving=0 afterwards.
REQ-030 Bench SHALL cover: door_cmd=1 in IDLE -> door_open_sts=1 after 2 cycles; door_cmd=0 -> door_open_sts=0 next cycle, IDLE after 2 more cycles.
REQ-031 Bench SHALL cover: dir_cmd=01 while in DOOR_OPEN -> fault=1 next cycle and sticky; rst -> fault=0, car_floor=00.
REQ-032 Bench SHALL cover: dir_cmd=01 at floor 3, or dir_cmd=11 -> fault=1 and no elevator_arrived pulse.
REQ-033 Bench SHALL cover: rst asserted at cycle 4 of travel -> IDLE, moving=0, car_floor=00, no arrival pulse.
